// File: rtl/portout_pkg.sv
// Shared types and constants for the port pipeline stage and its receive FIFO.
// Also provides the saturating increment used by the drop counter.
package portout_pkg;

  localparam int PORT_DW    = 8;
  localparam int DROP_CNT_W = 8;

  typedef logic [PORT_DW-1:0] port_data_t;

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    logic [DROP_CNT_W-1:0] r;
    if (v == {DROP_CNT_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + DROP_CNT_W'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/portout_fifo_mem.sv
// DEPTH x DW register array for the receive FIFO: one synchronous write port,
// one asynchronous read port so the head entry falls through without a clock.
module portout_fifo_mem #(
  parameter int DEPTH = 8,
  parameter int DW    = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/portout_rx_fifo.sv
// First-word-fall-through receive FIFO behind the port pipeline stage; overflow drops and counts.
// Define PORTOUT_FIFO_ASSERT_EN to compile the embedded concurrent assertions.
module portout_rx_fifo
  import portout_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int DW    = PORT_DW
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_in_valid,
  input  logic [DW-1:0]          i_in_data,
  output logic                   o_out_valid,
  input  logic                   i_out_ready,
  output logic [DW-1:0]          o_out_data,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty,
  output logic                   o_ovf,
  output logic [DROP_CNT_W-1:0]  o_drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_full;
  logic                  r_empty;
  logic                  r_ovf;
  logic [DROP_CNT_W-1:0] r_drop_cnt;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_drop;
  logic [AW-1:0]         w_wr_ptr_nxt;
  logic [AW-1:0]         w_rd_ptr_nxt;
  logic [CW-1:0]         w_count_nxt;
  logic [DW-1:0]         w_rdata;

  // A full FIFO still accepts a beat when the head leaves on the same edge.
  assign w_pop  = ~r_empty & i_out_ready;
  assign w_push = i_in_valid & (~r_full | w_pop);
  assign w_drop = i_in_valid & r_full & ~w_pop;

  always_comb begin
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    w_count_nxt  = r_count;
    if (w_push) begin
      w_wr_ptr_nxt = r_wr_ptr + AW'(1);
    end else begin
      w_wr_ptr_nxt = r_wr_ptr;
    end
    if (w_pop) begin
      w_rd_ptr_nxt = r_rd_ptr + AW'(1);
    end else begin
      w_rd_ptr_nxt = r_rd_ptr;
    end
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr   <= {AW{1'b0}};
      r_rd_ptr   <= {AW{1'b0}};
      r_count    <= {CW{1'b0}};
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_ovf      <= 1'b0;
      r_drop_cnt <= {DROP_CNT_W{1'b0}};
    end else begin
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_count    <= w_count_nxt;
      r_full     <= (w_count_nxt == FULL_CNT);
      r_empty    <= (w_count_nxt == {CW{1'b0}});
      r_ovf      <= r_ovf | w_drop;
      r_drop_cnt <= w_drop ? sat_inc(r_drop_cnt) : r_drop_cnt;
    end
  end

  portout_fifo_mem #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (w_push & ~i_rst),
    .i_waddr (r_wr_ptr),
    .i_wdata (i_in_data),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  assign o_out_valid = ~r_empty;
  assign o_out_data  = w_rdata;
  assign o_count     = r_count;
  assign o_full      = r_full;
  assign o_empty     = r_empty;
  assign o_ovf       = r_ovf;
  assign o_drop_cnt  = r_drop_cnt;

`ifdef PORTOUT_FIFO_ASSERT_EN
  // Follows one pushed beat at a time: data, entries ahead of it, cycles stalled at the head.
  logic          r_trk_act;
  logic [DW-1:0] r_trk_data;
  logic [CW-1:0] r_trk_ahead;
  logic [31:0]   r_trk_wait;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_trk_act   <= 1'b0;
      r_trk_data  <= {DW{1'b0}};
      r_trk_ahead <= {CW{1'b0}};
      r_trk_wait  <= 32'd0;
    end else if (!r_trk_act) begin
      r_trk_act   <= w_push;
      r_trk_data  <= i_in_data;
      r_trk_ahead <= r_count - (w_pop ? CW'(1) : CW'(0));
      r_trk_wait  <= 32'd0;
    end else if (w_pop) begin
      r_trk_act   <= (r_trk_ahead != {CW{1'b0}});
      r_trk_ahead <= r_trk_ahead - CW'(1);
      r_trk_wait  <= 32'd0;
    end else begin
      r_trk_wait  <= i_out_ready ? r_trk_wait + 32'd1 : 32'd0;
    end
  end

  a_count_range: assert property (@(posedge i_clk) disable iff (i_rst) r_count <= FULL_CNT)
    else $error("count out of range: count=%0d wr=%0d rd=%0d", r_count, r_wr_ptr, r_rd_ptr);
  a_full_not_empty: assert property (@(posedge i_clk) disable iff (i_rst) r_full |-> !r_empty)
    else $error("full and empty together: count=%0d wr=%0d rd=%0d", r_count, r_wr_ptr, r_rd_ptr);
  a_data_integrity: assert property (@(posedge i_clk) disable iff (i_rst)
      (r_trk_act && w_pop && r_trk_ahead == {CW{1'b0}}) |-> (o_out_data == r_trk_data))
    else $error("head data corrupted: count=%0d wr=%0d rd=%0d", r_count, r_wr_ptr, r_rd_ptr);
  a_data_timely: assert property (@(posedge i_clk) disable iff (i_rst)
      r_trk_wait < 32'(DEPTH * 16))
    else $error("tracked beat stalled: count=%0d wr=%0d rd=%0d", r_count, r_wr_ptr, r_rd_ptr);
  a_ovf_set: assert property (@(posedge i_clk) disable iff (i_rst)
      (i_in_valid && r_full && !w_pop) |=> r_ovf)
    else $error("drop without ovf: count=%0d wr=%0d rd=%0d", r_count, r_wr_ptr, r_rd_ptr);
`endif

endmodule

// File: tb/tb_portout_rx_fifo.sv
// Self-checking bench for portout_rx_fifo: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_portout_rx_fifo;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [7:0] out_data;
  logic [3:0] count;
  logic       full;
  logic       empty;
  logic       ovf;
  logic [7:0] drop_cnt;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] m_q[$];
  logic       m_ovf = 1'b0;
  int         m_drop = 0;

  always #5 clk = ~clk;

  portout_rx_fifo #(.DEPTH(DEPTH), .DW(8)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_in_valid  (in_valid),
    .i_in_data   (in_data),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_data  (out_data),
    .o_count     (count),
    .o_full      (full),
    .o_empty     (empty),
    .o_ovf       (ovf),
    .o_drop_cnt  (drop_cnt)
  );

  // Apply one cycle of inputs, advance the reference model over the edge, settle 1 time unit.
  task automatic tick(input logic v, input logic [7:0] d, input logic r, input logic rs);
    bit pop, push;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    rst       = rs;
    @(posedge clk);
    if (rs) begin
      m_q.delete();
      m_ovf  = 1'b0;
      m_drop = 0;
    end else begin
      pop  = (m_q.size() != 0) && r;
      push = v && ((m_q.size() < DEPTH) || pop);
      if (pop) void'(m_q.pop_front());
      if (push) m_q.push_back(d);
      else if (v) begin
        m_ovf = 1'b1;
        if (m_drop < 255) m_drop++;
      end
    end
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b0;
  endtask

  task automatic test_reset();
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) tick(1'b0, 8'h00, 1'b0, 1'b0);
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got %0b want 1", empty); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0b want 0", out_valid); end
    n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", count); end
    n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full got %0b want 0", full); end
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %0b want 0", ovf); end
    n_cmp++; if (drop_cnt !== 8'd0) begin n_err++; $display("FAIL reset_drop got %0d want 0", drop_cnt); end
  endtask

  task automatic test_fill_drain();
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) tick(1'b1, 8'(i), 1'b0, 1'b0);
    n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL fill_full got %0b want 1", full); end
    n_cmp++; if (count !== 4'd8) begin n_err++; $display("FAIL fill_count got %0d want 8", count); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== 8'(i)) begin
        n_err++; $display("FAIL drain_data[%0d] got v=%0b d=%0h want v=1 d=%0h", i, out_valid, out_data, i);
      end
      tick(1'b0, 8'h00, 1'b1, 1'b0);
    end
    n_cmp++; if (empty !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL drain_empty got e=%0b v=%0b want e=1 v=0", empty, out_valid); end
  endtask

  task automatic test_overflow();
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) tick(1'b1, 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
    n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %0b want 1", ovf); end
    n_cmp++; if (drop_cnt !== 8'd3) begin n_err++; $display("FAIL ovf_drop got %0d want 3", drop_cnt); end
    n_cmp++; if (count !== 4'd8) begin n_err++; $display("FAIL ovf_count got %0d want 8", count); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (out_data !== 8'(i)) begin n_err++; $display("FAIL ovf_contents[%0d] got %0h want %0h", i, out_data, i); end
      tick(1'b0, 8'h00, 1'b1, 1'b0);
    end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL ovf_empty got %0b want 1", empty); end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp_seq [8];
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) tick(1'b1, 8'(i), 1'b0, 1'b0);
    n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL pp_head got %0h want 0", out_data); end
    tick(1'b1, 8'h55, 1'b1, 1'b0);
    n_cmp++; if (count !== 4'd8 || full !== 1'b1) begin n_err++; $display("FAIL pp_count got %0d/%0b want 8/1", count, full); end
    n_cmp++; if (ovf !== 1'b0 || drop_cnt !== 8'd0) begin n_err++; $display("FAIL pp_ovf got %0b/%0d want 0/0", ovf, drop_cnt); end
    for (int i = 0; i < 7; i++) exp_seq[i] = 8'(i + 1);
    exp_seq[7] = 8'h55;
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (out_data !== exp_seq[i]) begin n_err++; $display("FAIL pp_order[%0d] got %0h want %0h", i, out_data, exp_seq[i]); end
      tick(1'b0, 8'h00, 1'b1, 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) tick(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
    tick(1'b1, 8'hEE, 1'b1, 1'b1);
    n_cmp++; if (count !== 4'd0 || out_valid !== 1'b0 || empty !== 1'b1) begin
      n_err++; $display("FAIL midrst_state got c=%0d v=%0b e=%0b want 0/0/1", count, out_valid, empty);
    end
    for (int i = 0; i < 8; i++) tick(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
    n_cmp++; if (full !== 1'b1 || ovf !== 1'b0) begin n_err++; $display("FAIL midrst_fill got f=%0b o=%0b want 1/0", full, ovf); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (out_data !== 8'hC0 + 8'(i)) begin n_err++; $display("FAIL midrst_order[%0d] got %0h want %0h", i, out_data, 8'hC0 + 8'(i)); end
      tick(1'b0, 8'h00, 1'b1, 1'b0);
    end
  endtask

  task automatic test_random();
    int pv, pr;
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    pv = 50; pr = 50;
    for (int c = 0; c < 10000; c++) begin
      if (c % 500 == 0) begin
        pv = $urandom_range(10, 95);
        pr = $urandom_range(10, 95);
      end
      tick(($urandom_range(0, 99) < pv), 8'($urandom), ($urandom_range(0, 99) < pr),
           ($urandom_range(0, 2999) == 0));
      n_cmp++;
      if (count !== 4'(m_q.size()) || out_valid !== (m_q.size() != 0) ||
          full !== (m_q.size() == DEPTH) || empty !== (m_q.size() == 0)) begin
        n_err++; $display("FAIL rnd_occ@%0d got c=%0d v=%0b f=%0b e=%0b want c=%0d", c, count, out_valid, full, empty, m_q.size());
      end
      n_cmp++;
      if (ovf !== m_ovf || drop_cnt !== 8'(m_drop)) begin
        n_err++; $display("FAIL rnd_ovf@%0d got %0b/%0d want %0b/%0d", c, ovf, drop_cnt, m_ovf, m_drop);
      end
      if (m_q.size() != 0) begin
        n_cmp++;
        if (out_data !== m_q[0]) begin n_err++; $display("FAIL rnd_data@%0d got %0h want %0h", c, out_data, m_q[0]); end
      end
    end
    for (int c = 0; c < 300; c++) tick(1'b1, 8'($urandom), 1'b0, 1'b0);
    n_cmp++; if (drop_cnt !== 8'd255 || m_drop != 255) begin n_err++; $display("FAIL rnd_sat got %0d want 255", drop_cnt); end
    n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL rnd_sat_ovf got %0b want 1", ovf); end
  endtask

  initial begin
    #2;
    test_reset();
    test_fill_drain();
    test_overflow();
    test_full_push_pop();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
